// File: rtl/microwave_timer_ctrl_if.sv
// Counter-chain bus between the cook-timer controller and the external
// MM:SS BCD down-counter chain.
interface microwave_timer_ctrl_if;
    logic        load_n;
    logic        cnt_en;
    logic [15:0] load_data;
    logic        timer_zero;

    modport master (
        output load_n,
        output cnt_en,
        output load_data,
        input  timer_zero
    );

    modport slave (
        input  load_n,
        input  cnt_en,
        input  load_data,
        output timer_zero
    );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer controller: keypad entry, load, run/pause, buzzer.
// Optional macro QUICK_START_EN: start in IDLE with empty entry cooks 30 s.
module microwave_timer_ctrl #(
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       tick,
    microwave_timer_ctrl_if.master cnt,
    output logic       mag_on,
    output logic       buzzer,
    output logic [2:0] state
);
    localparam int TW = $clog2(DONE_TICKS + 1);
    localparam logic [TW-1:0] LAST = TW'(DONE_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } st_e;

    st_e           st;
    logic [15:0]   entry;
    logic [TW-1:0] tcnt;
    logic [3:0]    sec_tens;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st    <= S_IDLE;
            entry <= '0;
            tcnt  <= '0;
        end else begin
            unique case (st)
                S_IDLE, S_ENTRY: begin
                    if (st == S_ENTRY && stop) begin
                        entry <= '0;
                        st    <= S_IDLE;
                    end else if (st == S_ENTRY && start && door_closed
                                 && entry != '0) begin
                        st <= S_LOAD;
`ifdef QUICK_START_EN
                    end else if (st == S_IDLE && entry == '0
                                 && start && door_closed) begin
                        entry <= 16'h0030;
                        st    <= S_LOAD;
`endif
                    end else if (key_valid && key_val <= 4'd9) begin
                        entry <= {entry[11:0], key_val};
                        st    <= S_ENTRY;
                    end
                end
                S_LOAD: st <= S_RUN;
                S_RUN: begin
                    if (cnt.timer_zero) begin
                        tcnt <= '0;
                        st   <= S_DONE;
                    end else if (stop || !door_closed) begin
                        st <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        entry <= '0;
                        st    <= S_IDLE;
                    end else if (start && door_closed) begin
                        st <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (stop) begin
                        entry <= '0;
                        tcnt  <= '0;
                        st    <= S_IDLE;
                    end else if (tick) begin
                        // counter stops at LAST, so it can never wrap
                        if (tcnt >= LAST) begin
                            entry <= '0;
                            tcnt  <= '0;
                            st    <= S_IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign sec_tens = (entry[7:4] > 4'd5) ? 4'd5 : entry[7:4];

    assign cnt.load_data = {entry[15:8], sec_tens, entry[3:0]};
    assign cnt.load_n    = (st != S_LOAD);
    // a tick coinciding with timer_zero must not underflow the chain
    assign cnt.cnt_en    = (st == S_LOAD)
                         | ((st == S_RUN) & tick & ~cnt.timer_zero);
    assign mag_on        = (st == S_RUN);
    assign buzzer        = (st == S_DONE);
    assign state         = st;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus random stimulus
// checked against a digit-level behavioural model.
module tb_microwave_timer_ctrl;
    localparam int DT = 3;

    logic       clk;
    logic       clr;
    logic       key_valid;
    logic [3:0] key_val;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       tick;
    logic       mag_on;
    logic       buzzer;
    logic [2:0] state;

    microwave_timer_ctrl_if cnt ();

    microwave_timer_ctrl #(.DONE_TICKS(DT)) dut (
        .clk         (clk),
        .clr         (clr),
        .key_valid   (key_valid),
        .key_val     (key_val),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .tick        (tick),
        .cnt         (cnt.master),
        .mag_on      (mag_on),
        .buzzer      (buzzer),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: state code, four entry digits (min_tens first), buzzer ticks
    int m_st;
    int m_dig [4];
    int m_tc;

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endfunction

    function automatic void model_reset();
        m_st = 0;
        m_tc = 0;
        model_clear();
    endfunction

    function automatic bit model_empty();
        return (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) == 0;
    endfunction

    function automatic logic [15:0] model_ld();
        int s;
        s = (m_dig[2] > 5) ? 5 : m_dig[2];
        return 16'(m_dig[0] * 4096 + m_dig[1] * 256 + s * 16 + m_dig[3]);
    endfunction

    function automatic bit model_cnt_en();
        return (m_st == 2) || (m_st == 3 && tick && !cnt.timer_zero);
    endfunction

    function automatic void model_step();
        bit quick;
        quick = 1'b0;
`ifdef QUICK_START_EN
        quick = 1'b1;
`endif
        case (m_st)
            0, 1: begin
                if (m_st == 1 && stop) begin
                    model_clear();
                    m_st = 0;
                end else if (m_st == 1 && start && door_closed
                             && !model_empty()) begin
                    m_st = 2;
                end else if (quick && m_st == 0 && model_empty()
                             && start && door_closed) begin
                    m_dig[2] = 3;
                    m_st = 2;
                end else if (key_valid && key_val <= 9) begin
                    m_dig[0] = m_dig[1];
                    m_dig[1] = m_dig[2];
                    m_dig[2] = m_dig[3];
                    m_dig[3] = int'(key_val);
                    m_st = 1;
                end
            end
            2: m_st = 3;
            3: begin
                if (cnt.timer_zero) begin
                    m_st = 5;
                    m_tc = 0;
                end else if (stop || !door_closed) begin
                    m_st = 4;
                end
            end
            4: begin
                if (stop) begin
                    model_clear();
                    m_st = 0;
                end else if (start && door_closed) begin
                    m_st = 3;
                end
            end
            5: begin
                if (stop) begin
                    model_clear();
                    m_tc = 0;
                    m_st = 0;
                end else if (tick) begin
                    m_tc++;
                    if (m_tc == DT) begin
                        model_clear();
                        m_tc = 0;
                        m_st = 0;
                    end
                end
            end
            default: m_st = 0;
        endcase
    endfunction

    task automatic set_in(input bit kv, input logic [3:0] k, input bit st,
                          input bit sp, input bit dc, input bit tk,
                          input bit tz);
        key_valid      = kv;
        key_val        = k;
        start          = st;
        stop           = sp;
        door_closed    = dc;
        tick           = tk;
        cnt.timer_zero = tz;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        set_in(1, d, 0, 0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic reset_dut();
        set_in(0, 0, 0, 0, 1, 0, 0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
    endtask

    task automatic to_run(input logic [3:0] d);
        reset_dut();
        press(d);
        set_in(0, 0, 1, 0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 0, 0);
        step();
    endtask

    task automatic test_reset();
        reset_dut();
        press(4'd7);
        clr = 1'b1;
        #1;
        n_cmp++; if (state !== 3'd0) begin n_bad++;
            $display("FAIL rst_state got %0d want 0", state); end
        n_cmp++; if (cnt.load_data !== 16'h0000) begin n_bad++;
            $display("FAIL rst_ld got %h want 0000", cnt.load_data); end
        n_cmp++; if ({cnt.load_n, cnt.cnt_en, mag_on, buzzer} !== 4'b1000)
            begin n_bad++; $display("FAIL rst_outs got %b want 1000",
            {cnt.load_n, cnt.cnt_en, mag_on, buzzer}); end
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_load_run();
        reset_dut();
        press(4'd1); press(4'd2); press(4'd3); press(4'd0);
        n_cmp++; if (state !== 3'd1) begin n_bad++;
            $display("FAIL entry_state got %0d want 1", state); end
        n_cmp++; if (cnt.load_data !== 16'h1230) begin n_bad++;
            $display("FAIL entry_ld got %h want 1230", cnt.load_data); end
        set_in(0, 0, 1, 0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if ({state, cnt.load_n, cnt.cnt_en} !== {3'd2, 2'b01})
            begin n_bad++; $display("FAIL load_pulse got %0d/%b%b want 2/01",
            state, cnt.load_n, cnt.cnt_en); end
        step();
        n_cmp++; if ({state, mag_on, cnt.load_n, cnt.cnt_en} !== {3'd3, 3'b110})
            begin n_bad++; $display("FAIL run_outs got %0d/%b%b%b want 3/110",
            state, mag_on, cnt.load_n, cnt.cnt_en); end
        set_in(0, 0, 0, 0, 1, 1, 0);
        #1;
        n_cmp++; if (cnt.cnt_en !== 1'b1) begin n_bad++;
            $display("FAIL run_tick_en got %b want 1", cnt.cnt_en); end
    endtask

    task automatic test_saturate();
        reset_dut();
        press(4'd0); press(4'd7); press(4'd5);
        n_cmp++; if (cnt.load_data !== 16'h0055) begin n_bad++;
            $display("FAIL sat_ld got %h want 0055", cnt.load_data); end
        press(4'd12);
        n_cmp++; if (cnt.load_data !== 16'h0055) begin n_bad++;
            $display("FAIL bad_key got %h want 0055", cnt.load_data); end
    endtask

    task automatic test_door_pause();
        to_run(4'd9);
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        n_cmp++; if ({state, mag_on} !== {3'd4, 1'b0}) begin n_bad++;
            $display("FAIL door_pause got %0d/%b want 4/0", state, mag_on); end
        set_in(0, 0, 1, 0, 0, 0, 0);
        step();
        n_cmp++; if (state !== 3'd4) begin n_bad++;
            $display("FAIL open_start got %0d want 4", state); end
        set_in(0, 0, 1, 0, 1, 0, 0);
        #1;
        n_cmp++; if (cnt.load_n !== 1'b1) begin n_bad++;
            $display("FAIL resume_load got %b want 1", cnt.load_n); end
        step();
        set_in(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if ({state, mag_on, cnt.load_n} !== {3'd3, 2'b11}) begin
            n_bad++; $display("FAIL resume got %0d/%b%b want 3/11",
            state, mag_on, cnt.load_n); end
    endtask

    task automatic test_done();
        to_run(4'd5);
        set_in(0, 0, 0, 1, 1, 1, 1);
        #1;
        n_cmp++; if (cnt.cnt_en !== 1'b0) begin n_bad++;
            $display("FAIL zero_tick_en got %b want 0", cnt.cnt_en); end
        step();
        n_cmp++; if ({state, buzzer, mag_on} !== {3'd5, 2'b10}) begin
            n_bad++; $display("FAIL done_enter got %0d/%b%b want 5/10",
            state, buzzer, mag_on); end
        for (int i = 0; i < DT; i++) begin
            set_in(0, 0, 0, 0, 1, 1, 0);
            #1;
            n_cmp++; if (cnt.cnt_en !== 1'b0) begin n_bad++;
                $display("FAIL done_en got %b want 0", cnt.cnt_en); end
            step();
            set_in(0, 0, 0, 0, 1, 0, 0);
            step();
            if (i < DT - 1) begin
                n_cmp++; if ({state, buzzer} !== {3'd5, 1'b1}) begin n_bad++;
                    $display("FAIL buzz_%0d got %0d/%b want 5/1",
                    i, state, buzzer); end
            end else begin
                n_cmp++; if ({state, buzzer} !== {3'd0, 1'b0}) begin n_bad++;
                    $display("FAIL buzz_end got %0d/%b want 0/0",
                    state, buzzer); end
            end
        end
    endtask

    task automatic test_stop_twice();
        to_run(4'd4);
        set_in(0, 0, 0, 1, 1, 0, 0);
        step();
        n_cmp++; if (state !== 3'd4) begin n_bad++;
            $display("FAIL stop1 got %0d want 4", state); end
        step();
        set_in(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if ({state, cnt.load_data} !== {3'd0, 16'h0000}) begin
            n_bad++; $display("FAIL stop2 got %0d/%h want 0/0000",
            state, cnt.load_data); end
    endtask

    task automatic test_quick_start();
        reset_dut();
        set_in(0, 0, 1, 0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 0, 0);
`ifdef QUICK_START_EN
        n_cmp++; if ({state, cnt.load_data} !== {3'd2, 16'h0030}) begin
            n_bad++; $display("FAIL quick_load got %0d/%h want 2/0030",
            state, cnt.load_data); end
        step();
        n_cmp++; if (state !== 3'd3) begin n_bad++;
            $display("FAIL quick_run got %0d want 3", state); end
`else
        n_cmp++; if (state !== 3'd0) begin n_bad++;
            $display("FAIL no_quick got %0d want 0", state); end
`endif
    endtask

    task automatic test_reset_midrun();
        to_run(4'd6);
        #2;
        clr = 1'b1;
        #1;
        n_cmp++; if ({state, mag_on} !== {3'd0, 1'b0}) begin n_bad++;
            $display("FAIL midrun_clr got %0d/%b want 0/0", state, mag_on); end
        @(posedge clk);
        #3;
        clr = 1'b0;
        model_reset();
        step();
        n_cmp++; if ({state, cnt.load_n, cnt.cnt_en} !== {3'd0, 2'b10}) begin
            n_bad++; $display("FAIL clr_release got %0d/%b%b want 0/10",
            state, cnt.load_n, cnt.cnt_en); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 1500; c++) begin
            set_in($urandom_range(99) < 35, 4'($urandom_range(15)),
                   $urandom_range(99) < 25, $urandom_range(99) < 6,
                   $urandom_range(99) < 88, $urandom_range(99) < 30,
                   $urandom_range(99) < 5);
            #1;
            n_cmp++; if (cnt.cnt_en !== model_cnt_en()) begin n_bad++;
                $display("FAIL rnd_en c%0d got %b want %b",
                c, cnt.cnt_en, model_cnt_en()); end
            step();
            n_cmp++; if (state !== 3'(m_st)) begin n_bad++;
                $display("FAIL rnd_state c%0d got %0d want %0d",
                c, state, m_st); end
            n_cmp++; if (cnt.load_data !== model_ld()) begin n_bad++;
                $display("FAIL rnd_ld c%0d got %h want %h",
                c, cnt.load_data, model_ld()); end
            n_cmp++;
            if ({cnt.load_n, mag_on, buzzer} !==
                {m_st != 2, m_st == 3, m_st == 5}) begin n_bad++;
                $display("FAIL rnd_outs c%0d got %b%b%b st %0d",
                c, cnt.load_n, mag_on, buzzer, m_st); end
        end
    endtask

    initial begin
        clr = 1'b1;
        set_in(0, 0, 0, 0, 1, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        test_reset();
        test_load_run();
        test_saturate();
        test_door_pause();
        test_done();
        test_stop_twice();
        test_quick_start();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/microwave_timer_ctrl.md
MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

Interface
REQ-001 Parameter: DONE_TICKS, default 3, number of tick pulses the buzzer stays on in DONE.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 clr  in  1  reset; asynchronous, active-high.
REQ-004 key_valid  in  1  one-cycle keypad strobe.
REQ-005 key_val  in  4  keypad digit; values 10-15 are invalid.
REQ-006 start  in  1  start/resume request, level sampled each cycle.
REQ-007 stop  in  1  pause/cancel request, level sampled each cycle.
REQ-008 door_closed  in  1  1 = door closed.
REQ-009 tick  in  1  one-cycle 1 Hz enable pulse.
REQ-010 timer_zero  in  1  1 = external MM:SS counter chain reads 00:00.
REQ-011 load_n  out  1  active-low load to counter chain.
REQ-012 cnt_en  out  1  count/load enable to counter chain.
REQ-013 load_data  out  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD.
REQ-014 mag_on  out  1  magnetron drive.
REQ-015 buzzer  out  1  end-of-cook alert.
REQ-016 state  out  3  encoding: IDLE=0, ENTRY=1, LOAD=2, RUN=3, PAUSE=4, DONE=5.

Function
REQ-017 FSM states: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE; one transition per clock maximum.
REQ-018 IDLE/ENTRY: key_valid with key_val<=9 shifts entry register left one digit (min_tens dropped), new digit to sec_ones, state->ENTRY; key_val>9 ignored.
REQ-019 load_data = entry register, with sec_tens saturated to 5 when entry sec_tens >5.
REQ-020 ENTRY: stop clears entry to 0 and goes IDLE; else start & door_closed & entry!=0 goes LOAD; stop beats start.
REQ-021 LOAD lasts exactly one cycle: load_n=0, cnt_en=1; next state RUN unconditionally.
REQ-022 RUN: mag_on=1; cnt_en=tick; load_n=1.
REQ-023 RUN priority: timer_zero -> DONE; else stop -> PAUSE; else !door_closed -> PAUSE; tick ignored in the cycle timer_zero is high.
REQ-024 PAUSE: mag_on=0, cnt_en=0; stop -> IDLE with entry cleared; else start & door_closed -> RUN (no reload); start with door open ignored.
REQ-025 DONE: buzzer=1, mag_on=0, cnt_en=0; tick counter increments per tick; after DONE_TICKS ticks -> IDLE, entry cleared; stop -> IDLE immediately.
REQ-026 Keypad input ignored in LOAD, RUN, PAUSE, DONE.
REQ-027 Outputs other than cnt_en are functions of registered state only; cnt_en in RUN is combinational from tick.
REQ-028 Tick counter width ceil(log2(DONE_TICKS+1)); saturates, never wraps.

Reset
REQ-029 clr high: state=IDLE, entry=0, tick counter=0, load_n=1, cnt_en=0, mag_on=0, buzzer=0, load_data=0, immediately without a clock.
REQ-030 clr asserted mid-RUN drops mag_on within the same cycle; no load pulse on release.

Configuration
REQ-031 Macro QUICK_START_EN defined: in IDLE with entry=0, start & door_closed loads entry 0x0030 and goes LOAD (30 s quick cook).
REQ-032 Macro QUICK_START_EN undefined: start in IDLE is ignored.

Verification
REQ-033 Keys 1,2,3,0 then start, door closed -> load_data=0x1230, one cycle load_n=0/cnt_en=1, then RUN with mag_on=1.
REQ-034 Keys 0,7,5 -> load_data=0x0055 (sec_tens 7 saturated to 5).
REQ-035 In RUN, door_closed->0 -> PAUSE next cycle, mag_on=0; door closed + start -> RUN, load_n stays 1.
REQ-036 In RUN, timer_zero=1 with tick=1 and stop=1 same cycle -> DONE, cnt_en=0 that cycle; buzzer high for 3 ticks, then IDLE.
REQ-037 Keys 4, start, then stop twice -> PAUSE, then IDLE, entry=0x0000.
REQ-038 With QUICK_START_EN: start in IDLE, no keys -> load_data=0x0030, LOAD then RUN; without macro state stays IDLE.
